// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling feeding a small receive FIFO
//
// Ports:
//   clk, rst        system clock (rising edge) and asynchronous active-high reset
//   uart_rxd        serial line, idle high, 8N1, LSB first
//   rx_data         byte at FIFO head, valid while rx_avail=1
//   rx_avail        FIFO not empty
//   rx_ack          pops the head byte when rx_avail=1
//   rx_ferr         sticky framing-error flag
//   rx_overrun      sticky overrun flag (byte dropped because FIFO was full)
//   err_clr         clears both sticky flags; a coincident new error wins

module uart_rx_fifo #(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    input  logic       rx_ack,
    output logic       rx_ferr,
    output logic       rx_overrun,
    input  logic       err_clr
);

    localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam int AW      = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(fifo_depth);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]    warm_q, warm_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [fifo_depth];
    logic [7:0]    mem_d [fifo_depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ferr_q, ferr_d, ovr_q, ovr_d;

    logic tick, fall, push, push_ok, pop, ferr_evt, ovr_evt, full, empty;

    always_comb begin
        sync1_d    = uart_rxd;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        // The sync flops reset to 1, so their first two post-reset samples are not
        // the real line; edges are only trusted once prev_q holds a genuine sample.
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        fall       = (warm_q == 2'd3) && prev_q && !sync2_q;
        tick       = (div_cnt_q == DIV_LAST);
        div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        state_d    = state_q;
        push       = 1'b0;
        ferr_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    // Re-phase the oversample grid to the start edge
                    state_d    = ST_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick && tick_cnt_q == 4'd7) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    tick_cnt_d = '0;
                    shift_d    = {sync2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    tick_cnt_d = '0;
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_evt = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        pop     = rx_ack && !empty;
        push_ok = push && (!full || pop);
        ovr_evt = push && full && !pop;

        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        ferr_d = ferr_evt || (ferr_q && !err_clr);
        ovr_d  = ovr_evt || (ovr_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            warm_q     <= 2'd0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_avail   = (count_q != '0);
    assign rx_ferr    = ferr_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo with a byte-queue model

module tb_uart_rx_fifo;

    localparam int DIV    = 5;
    localparam int BIT    = 16 * DIV;
    localparam int DEPTH  = 4;
    // Stop-bit sample edge counted from the start-bit negedge: two sync flops plus
    // edge detect (3 edges), then 8 + 8*16 + 16 oversample ticks of DIV clocks.
    // Controls driven on the negedge before it are seen in the push cycle.
    localparam int ACK_AT = 2 + DIV * (8 + 8 * 16 + 16);

    logic       clk = 1'b0;
    logic       rst, uart_rxd, rx_ack, err_clr;
    logic [7:0] rx_data;
    logic       rx_avail, rx_ferr, rx_overrun;

    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;

    logic [7:0] exp_q[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_avail  (rx_avail),
        .rx_ack    (rx_ack),
        .rx_ferr   (rx_ferr),
        .rx_overrun(rx_overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the model while the line is quiet
    always @(posedge clk) begin
        #2;
        if (chk_en && !rst) begin
            chk("model_avail", {31'd0, rx_avail}, {31'd0, exp_q.size() != 0});
            chk("model_ferr", {31'd0, rx_ferr}, {31'd0, exp_ferr});
            chk("model_ovr", {31'd0, rx_overrun}, {31'd0, exp_ovr});
            if (exp_q.size() != 0) chk("model_data", {24'd0, rx_data}, {24'd0, exp_q[0]});
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_push,
                              input bit clr_push);
        chk_en = 1'b0;
        fork
            begin
                uart_rxd = 1'b0;
                repeat (BIT) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    uart_rxd = b[i];
                    repeat (BIT) @(negedge clk);
                end
                uart_rxd = stop_ok;
                repeat (BIT) @(negedge clk);
                if (!stop_ok) begin
                    repeat (200) @(negedge clk);
                    uart_rxd = 1'b1;
                end
            end
            begin
                repeat (ACK_AT) @(negedge clk);
                rx_ack  = ack_push;
                err_clr = clr_push;
                @(negedge clk);
                rx_ack  = 1'b0;
                err_clr = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        if (ack_push && exp_q.size() != 0) void'(exp_q.pop_front());
        if (clr_push) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
        if (!stop_ok) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clr();
        err_clr  = 1'b1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        chk_en   = 1'b0;
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rxd = b[4];
        repeat (BIT / 2) @(negedge clk);
        rst      = 1'b1;
        uart_rxd = 1'b1;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk_en = 1'b1;
    endtask

    initial begin
        logic [7:0] burst [5];
        logic [7:0] fill [4];
        burst = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h55};
        fill  = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b1; uart_rxd = 1'b0; rx_ack = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_avail", {31'd0, rx_avail}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_ferr", {31'd0, rx_ferr}, 32'd0);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);

        // Line already low at release: must not be taken as a start bit
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (300) @(negedge clk);
        chk("low_rel_avail", {31'd0, rx_avail}, 32'd0);
        chk("low_rel_ferr", {31'd0, rx_ferr}, 32'd0);
        uart_rxd = 1'b1;
        repeat (100) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_avail", {31'd0, rx_avail}, 32'd1);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_ferr", {31'd0, rx_ferr}, 32'd0);
        do_ack();
        chk("a5_popped", {31'd0, rx_avail}, 32'd0);
        do_ack();
        chk("ack_empty", {31'd0, rx_avail}, 32'd0);

        chk_en = 1'b0;
        uart_rxd = 1'b0;
        repeat (20) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk_en = 1'b1;
        chk("glitch_avail", {31'd0, rx_avail}, 32'd0);

        for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b1, 1'b0, 1'b0);
        chk("ovr_set", {31'd0, rx_overrun}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovr_order", {24'd0, rx_data}, {24'd0, burst[i]});
            do_ack();
        end
        chk("ovr_drained", {31'd0, rx_avail}, 32'd0);
        do_clr();
        chk("ovr_clr", {31'd0, rx_overrun}, 32'd0);

        // Bad stop with err_clr in the same cycle: the new error must stick
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        chk("ferr_set", {31'd0, rx_ferr}, 32'd1);
        chk("ferr_nopush", {31'd0, rx_avail}, 32'd0);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        chk("after_break", {24'd0, rx_data}, 32'h42);
        do_ack();
        do_clr();
        chk("ferr_clr", {31'd0, rx_ferr}, 32'd0);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        reset_mid_frame(8'h99);
        chk("rst_mid_avail", {31'd0, rx_avail}, 32'd0);
        send_frame(8'h17, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_data", {24'd0, rx_data}, 32'h17);
        do_ack();
        chk("rst_mid_only", {31'd0, rx_avail}, 32'd0);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        chk("empty_pushpop", {24'd0, rx_data}, 32'h5A);
        do_ack();

        for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1, 1'b0, 1'b0);
        send_frame(8'h6E, 1'b1, 1'b1, 1'b0);
        chk("full_pushpop_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("full_rd0", {24'd0, rx_data}, 32'h22); do_ack();
        chk("full_rd1", {24'd0, rx_data}, 32'h33); do_ack();
        chk("full_rd2", {24'd0, rx_data}, 32'h44); do_ack();
        chk("full_rd3", {24'd0, rx_data}, 32'h6E); do_ack();
        chk("full_empty", {31'd0, rx_avail}, 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter clk_freq, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter uart_baud_rate, default 1152000, serial bit rate in baud.
REQ-003 SHALL have parameter fifo_depth, default 4, receive FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 uart_rxd  input  1  serial line, idle high, 8N1 frames, LSB first.
REQ-007 rx_data  output  8  byte at FIFO head, valid while rx_avail=1.
REQ-008 rx_avail  output  1  FIFO not empty.
REQ-009 rx_ack  input  1  consumer pops head byte on this cycle.
REQ-010 rx_ferr  output  1  sticky framing-error flag.
REQ-011 rx_overrun  output  1  sticky overrun flag.
REQ-012 err_clr  input  1  clears rx_ferr and rx_overrun.

Function
REQ-013 SHALL synchronise uart_rxd through two flops, both reset to 1; all sampling uses the second flop.
REQ-014 SHALL generate a 16x oversample tick every div = max(1, clk_freq/(uart_baud_rate*16)) clocks (integer truncation); one bit = 16 ticks.
REQ-015 Tick counter SHALL free-run in IDLE and restart at 0 on detection of a falling edge.
REQ-016 States: IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE -> START on synchronised line 1->0.
REQ-018 START: after 8 ticks sample line; 0 -> DATA, 1 -> IDLE (glitch rejected, nothing pushed).
REQ-019 DATA: sample every 16 ticks, shift in LSB first; after 8th bit -> STOP.
REQ-020 STOP: after 16 ticks sample; 1 -> push byte, -> IDLE; 0 -> set rx_ferr, discard byte, -> BREAK.
REQ-021 BREAK -> IDLE on first synchronised high sample; no new frame detected while in BREAK.
REQ-022 Pushed byte SHALL appear on rx_data/rx_avail one clock after the stop-bit sample cycle when the FIFO was empty.
REQ-023 rx_ack with rx_avail=1 SHALL pop one entry at that edge; rx_ack with rx_avail=0 SHALL be ignored.
REQ-024 Push while full and no pop in the same cycle: byte dropped, rx_overrun set, FIFO contents unchanged.
REQ-025 Push and pop in the same cycle when full: both performed, no overrun; when empty: push performed, pop ignored.
REQ-026 FIFO pointers SHALL wrap modulo fifo_depth; occupancy counter width log2(fifo_depth)+1.
REQ-027 err_clr SHALL clear both flags; a new error event in the same cycle as err_clr SHALL win (flag stays set).
REQ-028 rx_data SHALL be registered/read from FIFO head, never the in-progress shift register.

Reset
REQ-029 rst asserted SHALL immediately force: state IDLE, FIFO empty, rx_avail=0, rx_data=8'h00, rx_ferr=0, rx_overrun=0, sync flops=1, tick and bit counters 0.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial byte pushed after release.
REQ-031 After rst release with uart_rxd low, no frame SHALL start until a 1->0 edge is seen.

Verification (clk_freq=100000000, uart_baud_rate=1152000 -> div=5, bit=80 clocks)
REQ-032 Send 8'hA5 with valid stop -> rx_avail=1, rx_data=8'hA5, rx_ferr=0; rx_ack pulse -> rx_avail=0.
REQ-033 Send 8'h00,8'hFF,8'h3C,8'hC3 without ack, then 8'h55 -> first four read back in order, 8'h55 lost, rx_overrun=1; err_clr -> rx_overrun=0.
REQ-034 Low pulse of 20 clocks on idle line -> no push, state returns IDLE, rx_avail stays 0.
REQ-035 Send 8'h81 with stop bit 0, line held low 200 clocks, then high, then 8'h42 -> 8'h81 discarded, rx_ferr=1, 8'h42 received correctly.
REQ-036 Assert rst during bit 4 of 8'h99, release, send 8'h17 -> only 8'h17 in FIFO, flags 0.
REQ-037 FIFO full, rx_ack asserted in the stop-sample push cycle of 8'h6E -> no overrun, 8'h6E read last after three older bytes.
